// File: rtl/datapath_pkg.sv
// Shared types and default sizes for the multicycle datapath.
// Holds the opcode and FSM state enums used by the top and the bench.
package datapath_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_REG_COUNT = 4;
  localparam int DEF_PC_W      = 8;
  localparam int DEF_IMM_W     = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_ADDI = 3'b100,
    OP_LW   = 3'b101,
    OP_SW   = 3'b110,
    OP_BEQ  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

endpackage

// File: rtl/regfile_p.sv
// Register file: two async read ports, one sync write port,
// async active-low clear of every entry.
module regfile_p
  import datapath_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_COUNT = DEF_REG_COUNT,
  localparam int RIDX_W   = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RIDX_W-1:0] ra1,
  input  logic [RIDX_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [RIDX_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem [REG_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB datapath with handshaked memories.
// Define MULTICYCLE_DATAPATH_BEQ_EN to make opcode 111 a BEQ, else a NOP.
module multicycle_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_COUNT = DEF_REG_COUNT,
  parameter int PC_W      = DEF_PC_W,
  parameter int IMM_W     = DEF_IMM_W,
  localparam int RIDX_W   = $clog2(REG_COUNT),
  localparam int INSTR_W  = 3 + 2*RIDX_W + IMM_W
) (
  input  logic               sysclk,
  input  logic               sysrst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               retire,
  output logic [PC_W-1:0]    pc_o
);

  state_e state, state_n;

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    br_tgt;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  a_q, b_q, imm_q, res_q;
  logic [DATA_W-1:0]  alu_y, imm_x, rd1, rd2;
  logic [RIDX_W-1:0]  rs, rt;
  logic [IMM_W-1:0]   imm;
  opcode_e            op;
  logic               rf_we, is_mem, is_br;

  assign op  = opcode_e'(instr_q[INSTR_W-1 -: 3]);
  assign rs  = instr_q[IMM_W+2*RIDX_W-1 -: RIDX_W];
  assign rt  = instr_q[IMM_W+RIDX_W-1 -: RIDX_W];
  assign imm = instr_q[IMM_W-1:0];

  assign imm_x  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign pc_inc = pc_q + PC_W'(1);
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_br  = (op == OP_BEQ);

`ifdef MULTICYCLE_DATAPATH_BEQ_EN
  logic [PC_W-1:0] imm_pc;
  assign imm_pc = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign br_tgt = (a_q == b_q) ? pc_inc + imm_pc : pc_inc;
`else
  assign br_tgt = pc_inc;
`endif

  always_comb begin
    alu_y = '0;
    unique case (op)
      OP_ADD:  alu_y = a_q + b_q;
      OP_SUB:  alu_y = a_q - b_q;
      OP_AND:  alu_y = a_q & b_q;
      OP_OR:   alu_y = a_q | b_q;
      OP_ADDI,
      OP_LW,
      OP_SW:   alu_y = a_q + imm_q;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) state <= S_FETCH;
    else           state <= state_n;
  end

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    rf_we    = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = run;
        if (run && imem_valid) state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_mem: state_n = S_MEM;
          is_br: begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end
          default: state_n = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
        if (dmem_ack) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // res_q doubles as the load data register once the ack arrives
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (run && imem_valid) instr_q <= imem_rdata;
        end
        S_DECODE: begin
          a_q   <= rd1;
          b_q   <= rd2;
          imm_q <= imm_x;
        end
        S_EXEC: begin
          res_q <= alu_y;
          if (is_br) pc_q <= br_tgt;
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (op == OP_LW) res_q <= dmem_rdata;
            else             pc_q  <= pc_inc;
          end
        end
        S_WB:    pc_q <= pc_inc;
        default: pc_q <= pc_q;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc_o       = pc_q;
  assign dmem_addr  = (state == S_MEM) ? res_q : '0;
  assign dmem_wdata = (state == S_MEM) ? b_q : '0;

  regfile_p #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT)
  ) u_rf (
    .clk   (sysclk),
    .rst_n (sysrst_n),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (rf_we),
    .wa    (rt),
    .wd    (res_q)
  );

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed scenarios plus a random program
// checked per retired instruction against an arithmetic reference model.
module tb_multicycle_datapath;

  logic        sysclk   = 1'b0;
  logic        sysrst_n = 1'b0;
  logic        run      = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [9:0]  imem_rdata;
  logic        imem_valid = 1'b1;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic [7:0]  dmem_rdata = '0;
  logic        dmem_ack   = 1'b0;
  logic        retire;
  logic [7:0]  pc_o;

  logic        run16 = 1'b0;
  logic        imem_req16;
  logic [7:0]  imem_addr16;
  logic [11:0] imem_rdata16;
  logic        dmem_req16, dmem_we16;
  logic [15:0] dmem_addr16, dmem_wdata16;
  logic [15:0] dmem_rdata16 = '0;
  logic        dmem_ack16   = 1'b0;
  logic        retire16;
  logic [7:0]  pc16;

  logic [9:0]  prog   [256];
  logic [11:0] prog16 [256];

  int checks = 0;
  int errors = 0;

`ifdef MULTICYCLE_DATAPATH_BEQ_EN
  localparam int BEQ_PC = 5;
`else
  localparam int BEQ_PC = 6;
`endif

  always #5 sysclk = ~sysclk;

  assign imem_rdata   = prog[imem_addr];
  assign imem_rdata16 = prog16[imem_addr16];

  multicycle_datapath dut (
    .sysclk     (sysclk),
    .sysrst_n   (sysrst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .retire     (retire),
    .pc_o       (pc_o)
  );

  multicycle_datapath #(.DATA_W(16), .REG_COUNT(8)) dut16 (
    .sysclk     (sysclk),
    .sysrst_n   (sysrst_n),
    .run        (run16),
    .imem_req   (imem_req16),
    .imem_addr  (imem_addr16),
    .imem_rdata (imem_rdata16),
    .imem_valid (imem_valid),
    .dmem_req   (dmem_req16),
    .dmem_we    (dmem_we16),
    .dmem_addr  (dmem_addr16),
    .dmem_wdata (dmem_wdata16),
    .dmem_rdata (dmem_rdata16),
    .dmem_ack   (dmem_ack16),
    .retire     (retire16),
    .pc_o       (pc16)
  );

  // external data memory, transaction monitor and ack responder
  int         ack_delay = 0;
  int         cnt = 0, cur_len = 0, last_len = 0;
  logic [7:0] last_addr = '0, last_wdata = '0;
  logic       last_we = 1'b0, cur_stable = 1'b0, last_stable = 1'b0;
  logic [7:0] ext_mem [256];
  bit         ext_wr  [256];

  function automatic int mem_init(input int a);
    return (a * 37 + 11) & 255;
  endfunction

  always @(posedge sysclk) begin
    if (!sysrst_n) begin
      cur_len = 0;
    end else if (dmem_req) begin
      if (cur_len == 0) begin
        last_addr  = dmem_addr;
        last_wdata = dmem_wdata;
        last_we    = dmem_we;
        cur_stable = 1'b1;
      end else if (dmem_addr !== last_addr || dmem_wdata !== last_wdata
                   || dmem_we !== last_we) begin
        cur_stable = 1'b0;
      end
      cur_len++;
      if (dmem_ack) begin
        if (dmem_we) begin
          ext_mem[dmem_addr] = dmem_wdata;
          ext_wr[dmem_addr]  = 1'b1;
        end
        last_len    = cur_len;
        last_stable = cur_stable;
        cur_len     = 0;
      end
    end
    #2;
    if (!dmem_req) begin
      dmem_ack = 1'b0;
      cnt      = 0;
    end else if (cnt == ack_delay) begin
      dmem_ack   = 1'b1;
      dmem_rdata = ext_wr[dmem_addr] ? ext_mem[dmem_addr]
                                     : 8'(mem_init(int'(dmem_addr)));
    end else begin
      dmem_ack = 1'b0;
      cnt++;
    end
  end

  // reference model: architectural state only
  int m_reg [4];
  int m_pc;
  int m_mem [256];

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_pc = 0;
  endtask

  task automatic m_step(input int ins, output int lat);
    int op, rs, rt, imm, a, b, ea;
    op  = (ins >> 7) & 7;
    rs  = (ins >> 5) & 3;
    rt  = (ins >> 3) & 3;
    imm = ins & 7;
    if (imm > 3) imm -= 8;
    a    = m_reg[rs];
    b    = m_reg[rt];
    ea   = (a + imm) & 255;
    m_pc = (m_pc + 1) & 255;
    lat  = 4;
    case (op)
      0: m_reg[rt] = (a + b) & 255;
      1: m_reg[rt] = (a - b) & 255;
      2: m_reg[rt] = a & b;
      3: m_reg[rt] = a | b;
      4: m_reg[rt] = ea;
      5: begin
        m_reg[rt] = m_mem[ea];
        lat = 5 + ack_delay;
      end
      6: begin
        m_mem[ea] = b;
        lat = 4 + ack_delay;
      end
      default: begin
        lat = 3;
`ifdef MULTICYCLE_DATAPATH_BEQ_EN
        if (a == b) m_pc = (m_pc + imm) & 255;
`endif
      end
    endcase
  endtask

  function automatic logic [9:0] mk(input int op, rs, rt, imm);
    return 10'((op << 7) | (rs << 5) | (rt << 3) | (imm & 7));
  endfunction

  function automatic logic [11:0] mk16(input int op, rs, rt, imm);
    return 12'((op << 9) | (rs << 6) | (rt << 3) | (imm & 7));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    run   = 1'b0;
    run16 = 1'b0;
    @(negedge sysclk);
    sysrst_n = 1'b0;
    #1;
    check("rst pc_o", 32'(pc_o), 0);
    check("rst imem_req", 32'(imem_req), 0);
    check("rst dmem_req", 32'(dmem_req), 0);
    check("rst dmem_we", 32'(dmem_we), 0);
    check("rst retire", 32'(retire), 0);
    check("rst dmem_addr", 32'(dmem_addr), 0);
    check("rst dmem_wdata", 32'(dmem_wdata), 0);
    @(negedge sysclk);
    sysrst_n = 1'b1;
    m_reset();
  endtask

  task automatic start();
    @(posedge sysclk);
    #1;
    run = 1'b1;
  endtask

  task automatic exec_one(input string tag);
    int n, lat;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!retire && n < 60);
    if (!retire) begin
      check({tag, " retire timeout"}, 32'(retire), 1);
      return;
    end
    m_step(int'(prog[m_pc]), lat);
    check({tag, " latency"}, n, lat);
    @(posedge sysclk);
    #1;
    check({tag, " pc"}, 32'(pc_o), m_pc);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s r%0d", tag, i), 32'(dut.u_rf.mem[i]), m_reg[i]);
  endtask

  task automatic wait16(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!retire16 && n < 60);
    if (!retire16) check({tag, " retire timeout"}, 32'(retire16), 1);
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    int n, seen_req, seen_ret;
    for (int a = 0; a < 256; a++) begin
      m_mem[a]  = mem_init(a);
      prog[a]   = mk(2, 3, 3, 0);
      prog16[a] = mk16(2, 7, 7, 0);
    end

    // ADDI then an idle window with run low
    do_reset();
    prog[0] = mk(4, 0, 1, 3);
    start();
    exec_one("addi");
    run = 1'b0;
    check("addi r1", 32'(dut.u_rf.mem[1]), 32'h03);
    check("addi pc", 32'(pc_o), 1);
    seen_req = 0;
    seen_ret = 0;
    repeat (10) begin
      @(negedge sysclk);
      if (imem_req) seen_req++;
      if (retire) seen_ret++;
    end
    check("idle imem_req", seen_req, 0);
    check("idle retire", seen_ret, 0);
    check("idle pc", 32'(pc_o), 1);

    // wrap-around ALU ops, then a slow store
    prog[1] = mk(4, 0, 1, 7);
    prog[2] = mk(4, 0, 2, 1);
    prog[3] = mk(0, 1, 2, 0);
    prog[4] = mk(0, 1, 2, 0);
    prog[5] = mk(1, 0, 2, 0);
    prog[6] = mk(6, 0, 1, 2);
    start();
    exec_one("ldff");
    exec_one("ld01");
    exec_one("add");
    check("add wrap r2", 32'(dut.u_rf.mem[2]), 32'h00);
    exec_one("add2");
    exec_one("sub");
    check("sub r2", 32'(dut.u_rf.mem[2]), 32'h01);
    ack_delay = 3;
    exec_one("sw");
    run = 1'b0;
    check("sw req cycles", last_len, 4);
    check("sw addr", 32'(last_addr), 32'h02);
    check("sw wdata", 32'(last_wdata), 32'hFF);
    check("sw we", 32'(last_we), 1);
    check("sw stable", 32'(last_stable), 1);
    check("sw mem", 32'(ext_mem[2]), 32'hFF);
    ack_delay = 0;

    // opcode 111 at pc 5 with imm -1
    do_reset();
    prog[5] = mk(7, 0, 0, 7);
    start();
    for (int i = 0; i < 6; i++) exec_one("beq");
    run = 1'b0;
    check("beq pc", 32'(pc_o), BEQ_PC);

    // reset while a load is waiting for its ack
    do_reset();
    prog[0] = mk(5, 0, 3, 1);
    ack_delay = 5;
    start();
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge sysclk);
      n++;
    end
    check("lw in mem", 32'(dmem_req), 1);
    #2;
    sysrst_n = 1'b0;
    run = 1'b0;
    #1;
    check("abort dmem_req", 32'(dmem_req), 0);
    check("abort dmem_we", 32'(dmem_we), 0);
    @(negedge sysclk);
    sysrst_n = 1'b1;
    m_reset();
    repeat (2) @(negedge sysclk);
    check("abort r3", 32'(dut.u_rf.mem[3]), 0);
    check("abort pc", 32'(pc_o), 0);
    ack_delay = 0;

    // random program against the model
    do_reset();
    ack_delay = 1;
    for (int a = 0; a < 256; a++)
      prog[a] = mk($urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 7));
    start();
    repeat (200) exec_one("rand");
    run = 1'b0;
    ack_delay = 0;

    // PC wrap through 0xFF
    do_reset();
    for (int a = 0; a < 256; a++) prog[a] = mk(7, 0, 0, 0);
    start();
    repeat (256) exec_one("wrap");
    run = 1'b0;
    check("pc wrap", 32'(pc_o), 0);

    // wide configuration, same sequence
    do_reset();
    prog16[0] = mk16(4, 0, 1, 3);
    prog16[1] = mk16(4, 0, 1, 7);
    prog16[2] = mk16(4, 0, 2, 1);
    prog16[3] = mk16(0, 1, 2, 0);
    prog16[4] = mk16(0, 1, 2, 0);
    prog16[5] = mk16(1, 0, 2, 0);
    @(posedge sysclk);
    #1;
    run16 = 1'b1;
    wait16("w16 addi");
    check("w16 r1", 32'(dut16.u_rf.mem[1]), 32'h0003);
    wait16("w16 ldff");
    wait16("w16 ld01");
    wait16("w16 add");
    check("w16 add wrap r2", 32'(dut16.u_rf.mem[2]), 32'h0000);
    wait16("w16 add2");
    wait16("w16 sub");
    run16 = 1'b0;
    check("w16 sub r2", 32'(dut16.u_rf.mem[2]), 32'h0001);
    check("w16 pc", 32'(pc16), 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
